// File: rtl/duc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : duc_ctrl_pkg
//  Contents  : State encoding, config register map and default drain length
//              shared by the DUC transmit controller.
//  Revision  : 1.0 - initial release
// ============================================================================
package duc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] CFG_FREQ = 2'd0;
    localparam logic [1:0] CFG_RATE = 2'd1;
    localparam logic [1:0] CFG_UCLR = 2'd2;

    localparam int DRAIN_STROBES_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/duc_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : duc_tx_ctrl
//  Purpose   : Transmit DUC sequencer - config shadowing, start/stop with zero
//              flush, per-strobe sample feed from a show-ahead FIFO, underrun.
//  Revision  : 1.0 - initial release
// ============================================================================
module duc_tx_ctrl
    import duc_ctrl_pkg::*;
#(
    parameter int IW            = 16,
    parameter int DRAIN_STROBES = DRAIN_STROBES_DEFAULT,
    parameter int UCNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    input  logic              fifo_empty,
    input  logic [2*IW-1:0]   fifo_data,
    output logic              fifo_rd,
    input  logic              duc_strobe,
    output logic              duc_enable,
    output logic [3:0]        duc_rate1,
    output logic [3:0]        duc_rate2,
    output logic [31:0]       duc_freq,
    output logic [IW-1:0]     duc_i,
    output logic [IW-1:0]     duc_q,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int              DCW        = (DRAIN_STROBES > 1) ? $clog2(DRAIN_STROBES) : 1;
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_STROBES - 1);
    localparam logic [DCW-1:0]  DCNT_ONE   = {{(DCW-1){1'b0}}, 1'b1};
    localparam logic [UCNT_W-1:0] UCNT_MAX = '1;
    localparam logic [UCNT_W-1:0] UCNT_ONE = {{(UCNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_sh_freq;
    logic [3:0]         r_sh_rate1;
    logic [3:0]         r_sh_rate2;
    logic [31:0]        r_freq;
    logic [3:0]         r_rate1;
    logic [3:0]         r_rate2;
    logic [IW-1:0]      r_i;
    logic [IW-1:0]      r_q;
    logic [DCW-1:0]     r_drain_cnt;
    logic               r_underrun;
    logic [UCNT_W-1:0]  r_ucnt;

    logic               w_fifo_rd;
    logic               w_load_fifo;
    logic               w_load_zero;
    logic               w_underrun_evt;
    logic               w_ucnt_clr;
    logic               w_active;

    assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_ucnt_clr = cfg_wr && (cfg_addr == CFG_UCLR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fifo_rd      = 1'b0;
        w_load_fifo    = 1'b0;
        w_load_zero    = 1'b0;
        w_underrun_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_zero = 1'b1;
                if (start && !stop) begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // Stop wins over a pending pop so the FIFO head is left untouched.
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (!fifo_empty) begin
                    w_fifo_rd   = 1'b1;
                    w_load_fifo = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (duc_strobe) begin
                    if (!fifo_empty) begin
                        w_fifo_rd   = 1'b1;
                        w_load_fifo = 1'b1;
                    end else begin
                        w_load_zero    = 1'b1;
                        w_underrun_evt = 1'b1;
                    end
                end
                if (stop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_load_zero = 1'b1;
                if (duc_strobe && (r_drain_cnt == DRAIN_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow registers take every write; active copies below read the pre-write value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sh_freq  <= '0;
            r_sh_rate1 <= '0;
            r_sh_rate2 <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr == CFG_FREQ) begin
                r_sh_freq <= cfg_data;
            end
            if (cfg_addr == CFG_RATE) begin
                r_sh_rate1 <= cfg_data[3:0];
                r_sh_rate2 <= cfg_data[7:4];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_freq  <= '0;
            r_rate1 <= '0;
            r_rate2 <= '0;
        end else if (r_state == ST_IDLE) begin
            r_freq  <= r_sh_freq;
            r_rate1 <= r_sh_rate1;
            r_rate2 <= r_sh_rate2;
        end else if (w_active && duc_strobe) begin
            // Frequency retunes only on a sample boundary so the NCO step is clean.
            r_freq <= r_sh_freq;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_q <= '0;
        end else if (w_load_fifo) begin
            r_i <= fifo_data[2*IW-1:IW];
            r_q <= fifo_data[IW-1:0];
        end else if (w_load_zero) begin
            r_i <= '0;
            r_q <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (r_state != ST_DRAIN) begin
            r_drain_cnt <= '0;
        end else if (duc_strobe) begin
            r_drain_cnt <= r_drain_cnt + DCNT_ONE;
        end
    end

    // A new underrun in the clear cycle still registers, counting from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
            if (w_ucnt_clr) begin
                r_ucnt <= UCNT_ONE;
            end else if (r_ucnt != UCNT_MAX) begin
                r_ucnt <= r_ucnt + UCNT_ONE;
            end
        end else if (w_ucnt_clr) begin
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign duc_enable   = w_active;
    assign fifo_rd      = w_fifo_rd;
    assign duc_rate1    = r_rate1;
    assign duc_rate2    = r_rate2;
    assign duc_freq     = r_freq;
    assign duc_i        = r_i;
    assign duc_q        = r_q;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_duc_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_duc_tx_ctrl
//  Purpose   : Self-checking bench for duc_tx_ctrl with a queue-based FIFO and
//              a behavioural transmit-sequencer reference model.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_duc_tx_ctrl;

    localparam int IW   = 16;
    localparam int DS   = 8;
    localparam int UW   = 4;
    localparam int UMAX = (1 << UW) - 1;
    localparam int MD_IDLE = 0, MD_PRIME = 1, MD_RUN = 2, MD_DRAIN = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [31:0]   cfg_data = 32'd0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          fifo_empty = 1'b1;
    logic [31:0]   fifo_data = 32'd0;
    logic          fifo_rd;
    logic          duc_strobe = 1'b0;
    logic          duc_enable;
    logic [3:0]    duc_rate1;
    logic [3:0]    duc_rate2;
    logic [31:0]   duc_freq;
    logic [IW-1:0] duc_i;
    logic [IW-1:0] duc_q;
    logic          underrun;
    logic [UW-1:0] underrun_cnt;

    duc_tx_ctrl #(.IW(IW), .DRAIN_STROBES(DS), .UCNT_W(UW)) dut (
        .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .stop(stop), .busy(busy),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .duc_strobe(duc_strobe), .duc_enable(duc_enable), .duc_rate1(duc_rate1),
        .duc_rate2(duc_rate2), .duc_freq(duc_freq), .duc_i(duc_i), .duc_q(duc_q),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] fifo_q[$];

    // Reference model state
    int          m_mode, m_drain, m_ucnt;
    logic [31:0] m_sh_freq, m_freq, m_iq;
    logic [3:0]  m_sh_r1, m_sh_r2, m_r1, m_r2;
    bit          m_ur;

    bit s_auto = 1'b0;
    int s_lo = 2, s_hi = 9, s_wait = 0;
    bit last_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic model_reset();
        m_mode = MD_IDLE; m_drain = 0; m_ucnt = 0; m_ur = 1'b0;
        m_sh_freq = '0; m_freq = '0; m_iq = '0;
        m_sh_r1 = '0; m_sh_r2 = '0; m_r1 = '0; m_r2 = '0;
    endtask

    // One clock edge of the sequencer as the behaviour rules describe it.
    task automatic model_step();
        bit          emp  = (fifo_q.size() == 0);
        logic [31:0] head = emp ? 32'd0 : fifo_q[0];
        bit          clr  = cfg_wr && (cfg_addr == 2'd2);
        bit          ev   = (m_mode == MD_RUN) && duc_strobe && emp;
        if (m_mode == MD_IDLE) begin
            m_r1 = m_sh_r1; m_r2 = m_sh_r2; m_freq = m_sh_freq;
        end else if (m_mode >= MD_RUN && duc_strobe) begin
            m_freq = m_sh_freq;
        end
        if (cfg_wr && cfg_addr == 2'd0) m_sh_freq = cfg_data;
        if (cfg_wr && cfg_addr == 2'd1) begin
            m_sh_r1 = cfg_data[3:0]; m_sh_r2 = cfg_data[7:4];
        end
        if (ev) begin
            m_ur = 1'b1;
            if (clr) m_ucnt = 0;
            if (m_ucnt < UMAX) m_ucnt++;
        end else if (clr) begin
            m_ur = 1'b0; m_ucnt = 0;
        end
        case (m_mode)
            MD_IDLE: begin
                m_iq = '0;
                if (start && !stop) m_mode = MD_PRIME;
            end
            MD_PRIME: begin
                if (stop) m_mode = MD_IDLE;
                else if (!emp) begin m_iq = head; m_mode = MD_RUN; end
            end
            MD_RUN: begin
                if (duc_strobe) m_iq = emp ? 32'd0 : head;
                if (stop) begin m_mode = MD_DRAIN; m_drain = 0; end
            end
            default: begin
                m_iq = '0;
                if (duc_strobe) begin
                    m_drain++;
                    if (m_drain == DS) m_mode = MD_IDLE;
                end
            end
        endcase
    endtask

    task automatic tick();
        bit rd_seen;
        bit exp_rd;
        if (s_auto) begin
            if (s_wait == 0) begin
                duc_strobe = 1'b1;
                s_wait = $urandom_range(s_hi, s_lo) - 1;
            end else begin
                s_wait--;
            end
        end
        @(negedge clock);
        exp_rd = !fifo_empty && ((m_mode == MD_PRIME && !stop) || (m_mode == MD_RUN && duc_strobe));
        check("busy", busy, m_mode != MD_IDLE);
        check("duc_enable", duc_enable, m_mode >= MD_RUN);
        check("fifo_rd", fifo_rd, exp_rd);
        check("duc_i", duc_i, m_iq[31:16]);
        check("duc_q", duc_q, m_iq[15:0]);
        check("duc_rate1", duc_rate1, m_r1);
        check("duc_rate2", duc_rate2, m_r2);
        check("duc_freq", duc_freq, m_freq);
        check("underrun", underrun, m_ur);
        check("underrun_cnt", underrun_cnt, m_ucnt);
        last_en = duc_enable;
        rd_seen = fifo_rd;
        @(posedge clock);
        #1;
        model_step();
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
        cfg_wr = 1'b0; start = 1'b0; stop = 1'b0; duc_strobe = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
    endtask

    task automatic strobe_run(input int n, input int gap);
        repeat (n) begin
            duc_strobe = 1'b1;
            tick();
            repeat (gap - 1) tick();
        end
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_duc_enable", duc_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_duc_i", duc_i, 0);
        check("rst_duc_q", duc_q, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] w [8];
        int n;
        model_reset();
        fifo_refresh();
        repeat (2) @(posedge clock);
        #1;
        check("init_enable", duc_enable, 0);
        check("init_busy", busy, 0);
        check("init_fifo_rd", fifo_rd, 0);
        check("init_duc_i", duc_i, 0);
        check("init_freq", duc_freq, 0);
        check("init_underrun", underrun, 0);
        reset = 1'b0;

        // Configure in IDLE, then play out four preloaded words
        cfg_write(2'd1, 32'h31);
        cfg_write(2'd0, 32'h1000_0000);
        tick();
        check("cfg_rate1", duc_rate1, 4'd1);
        check("cfg_rate2", duc_rate2, 4'd3);
        check("cfg_freq", duc_freq, 32'h1000_0000);
        for (int k = 0; k < 4; k++) begin
            w[k] = $urandom;
            push_word(w[k]);
        end
        start = 1'b1;
        tick();
        tick();
        check("first_sample_i", duc_i, w[0][31:16]);
        check("first_enable", duc_enable, 1);
        strobe_run(3, 8);
        check("fifo_drained", fifo_q.size(), 0);
        check("last_sample_q", duc_q, w[3][15:0]);

        // Underrun then refill
        cfg_write(2'd2, 32'd0);
        w[4] = $urandom; w[5] = $urandom;
        push_word(w[4]); push_word(w[5]);
        strobe_run(5, 8);
        check("ur_flag", underrun, 1);
        check("ur_count3", underrun_cnt, 3);
        check("ur_zero_i", duc_i, 0);
        for (int k = 5; k < 8; k++) begin
            w[k] = $urandom;
            push_word(w[k]);
        end
        strobe_run(3, 8);
        check("refill_i", duc_i, w[7][31:16]);

        // Config writes while running
        cfg_write(2'd1, 32'h77);
        cfg_write(2'd0, 32'hABCD_0123);
        repeat (3) tick();
        check("run_rate1_held", duc_rate1, 4'd1);
        check("run_freq_held", duc_freq, 32'h1000_0000);
        duc_strobe = 1'b1;
        tick();
        check("run_freq_strobe", duc_freq, 32'hABCD_0123);

        // Underrun coincident with counter clear, then saturation
        tick();
        cfg_wr = 1'b1; cfg_addr = 2'd2; duc_strobe = 1'b1;
        tick();
        check("clr_set_flag", underrun, 1);
        check("clr_set_cnt", underrun_cnt, 1);
        strobe_run(20, 2);
        check("ur_saturate", underrun_cnt, UMAX);

        // Stop, drain with a stray start, back to IDLE
        stop = 1'b1;
        tick();
        tick();
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            duc_strobe = 1'b1;
            tick();
            if (last_en) n++;
            if (k == 3) start = 1'b1;
            repeat (7) tick();
        end
        check("drain_strobes", n, DS);
        check("drain_idle_busy", busy, 0);
        check("drain_idle_en", duc_enable, 0);
        tick();
        check("idle_rate1", duc_rate1, 4'd7);
        check("idle_rate2", duc_rate2, 4'd7);

        // start together with stop in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        tick();
        check("start_stop_idle", busy, 0);

        // Asynchronous reset while running
        for (int k = 0; k < 3; k++) push_word($urandom);
        start = 1'b1;
        tick();
        tick();
        strobe_run(1, 4);
        check("pre_reset_en", duc_enable, 1);
        async_reset();
        check("reset_fifo_kept", fifo_q.size(), 1);

        // Randomized traffic
        s_auto = 1'b1; s_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (c == 2000) async_reset();
            r = $urandom_range(99);
            if (r < 3) start = 1'b1;
            else if (r < 5) stop = 1'b1;
            if ($urandom_range(99) < 5) begin
                cfg_wr = 1'b1; cfg_addr = 2'($urandom_range(3)); cfg_data = $urandom;
            end
            if (fifo_q.size() < 12 && $urandom_range(99) < 15) push_word($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
